// File: rtl/mod_counter_pkg.sv
// Shared constants and helpers for the programmable modulo counter.
// Optional wrap-event counter is enabled by MOD_COUNTER_WRAPCNT_EN.
package mod_counter_pkg;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   localparam int MAX_BITS = 32;

   // Modulus 0 stands for the full 2^bits range
   function automatic logic [MAX_BITS:0] eff_mod(
      input logic [MAX_BITS-1:0] mod_val,
      input int                  bits
   );
      logic [MAX_BITS:0] m;
      m = {1'b0, mod_val};
      if (mod_val == '0) begin
         m = {{MAX_BITS{1'b0}}, 1'b1} << bits;
      end
      return m;
   endfunction

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-count and terminal-condition logic.
// Wraps at Meff-1 going up and at 0 going down.
module mod_counter_next
   import mod_counter_pkg::*;
#(
   parameter int BITS = 4
) (
   input  logic [BITS-1:0] q_i,
   input  logic [BITS:0]   meff_i,
   input  logic            up_dn_i,
   output logic [BITS-1:0] q_next_o,
   output logic            term_o
);

   logic [BITS:0] q_x;
   logic [BITS:0] top_x;

   assign q_x   = {1'b0, q_i};
   assign top_x = meff_i - {{BITS{1'b0}}, 1'b1};

   always_comb begin
      q_next_o = q_i;
      term_o   = 1'b0;
      unique case (up_dn_i)
         DIR_UP: begin
            if (q_x >= top_x) begin
               q_next_o = '0;
               term_o   = 1'b1;
            end else begin
               q_next_o = q_i + 1'b1;
            end
         end
         DIR_DN: begin
            // Out-of-range values re-enter at the top without a wrap event
            if (q_i == '0) begin
               q_next_o = top_x[BITS-1:0];
               term_o   = 1'b1;
            end else if (q_x > top_x) begin
               q_next_o = top_x[BITS-1:0];
            end else begin
               q_next_o = q_i - 1'b1;
            end
         end
      endcase
   end

endmodule

// File: rtl/mod_counter_prog.sv
// Runtime-programmable up/down modulo counter with load and cascade tc.
// Define MOD_COUNTER_WRAPCNT_EN to add the saturating wrap_cnt output.
module mod_counter_prog
   import mod_counter_pkg::*;
#(
   parameter int BITS = 4
`ifdef MOD_COUNTER_WRAPCNT_EN
   ,
   parameter int WRAP_BITS = 8
`endif
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic                 up_dn,
   input  logic                 load,
   input  logic [BITS-1:0]      load_val,
   input  logic [BITS-1:0]      mod_val,
   output logic [BITS-1:0]      Q,
   output logic                 tc
`ifdef MOD_COUNTER_WRAPCNT_EN
   ,
   output logic [WRAP_BITS-1:0] wrap_cnt
`endif
);

   logic [BITS-1:0] q_q;
   logic [BITS-1:0] q_d;
   logic [BITS-1:0] q_next;
   logic [BITS:0]   meff;
   logic            term;

   assign meff = (BITS+1)'(eff_mod(32'(mod_val), BITS));

   mod_counter_next #(
      .BITS(BITS)
   ) u_next (
      .q_i     (q_q),
      .meff_i  (meff),
      .up_dn_i (up_dn),
      .q_next_o(q_next),
      .term_o  (term)
   );

   // Unregistered so a downstream digit can use it as its enable
   assign tc = enable & ~load & reset_n & term;

   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = load_val;
      end else if (enable) begin
         q_d = q_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign Q = q_q;

`ifdef MOD_COUNTER_WRAPCNT_EN
   logic [WRAP_BITS-1:0] wrap_q;
   logic [WRAP_BITS-1:0] wrap_d;

   always_comb begin
      wrap_d = wrap_q;
      if (load) begin
         wrap_d = '0;
      end else if (tc && (wrap_q != {WRAP_BITS{1'b1}})) begin
         wrap_d = wrap_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wrap_q <= '0;
      end else begin
         wrap_q <= wrap_d;
      end
   end

   assign wrap_cnt = wrap_q;
`endif

endmodule

// File: tb/tb_mod_counter_prog.sv
// Scoreboard bench for mod_counter_prog (BITS=4, WRAP_BITS=2 when enabled).
// Driver queues expected tc/Q/wrap_cnt; monitor compares each cycle.
module tb_mod_counter_prog;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       enable = 1'b0;
   logic       up_dn = 1'b1;
   logic       load = 1'b0;
   logic [3:0] load_val = 4'd0;
   logic [3:0] mod_val = 4'd12;
   logic [3:0] Q;
   logic       tc;
`ifdef MOD_COUNTER_WRAPCNT_EN
   logic [1:0] wrap_cnt;
`endif

   typedef struct {
      logic [3:0] q;
      logic       tc;
      logic [1:0] w;
      int         id;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   n_id   = 0;
   logic [1:0] exp_w = 2'd0;

   always #5 clk = ~clk;

   mod_counter_prog #(
      .BITS(4)
`ifdef MOD_COUNTER_WRAPCNT_EN
      ,
      .WRAP_BITS(2)
`endif
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (enable),
      .up_dn   (up_dn),
      .load    (load),
      .load_val(load_val),
      .mod_val (mod_val),
      .Q       (Q),
      .tc      (tc)
`ifdef MOD_COUNTER_WRAPCNT_EN
      ,
      .wrap_cnt(wrap_cnt)
`endif
   );

   // One cycle: apply inputs, queue the tc seen this cycle and state after
   task automatic drv(input logic rn, input logic en, input logic ud,
                      input logic ld, input logic [3:0] lv,
                      input logic [3:0] mv, input logic [3:0] eq,
                      input logic etc);
      exp_t e;
      @(negedge clk);
      reset_n  = rn;
      enable   = en;
      up_dn    = ud;
      load     = ld;
      load_val = lv;
      mod_val  = mv;
      if (!rn || ld) exp_w = 2'd0;
      else if (etc && exp_w != 2'd3) exp_w = exp_w + 2'd1;
      e.q  = eq;
      e.tc = etc;
      e.w  = exp_w;
      e.id = n_id;
      n_id++;
      sb.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      logic tc_s;
      forever begin
         @(negedge clk);
         #3;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            tc_s = tc;
            @(posedge clk);
            #1;
            checks++;
            if (tc_s !== e.tc) begin
               errors++;
               $display("FAIL tc id=%0d got %b want %b", e.id, tc_s, e.tc);
            end
            checks++;
            if (Q !== e.q) begin
               errors++;
               $display("FAIL q id=%0d got %0d want %0d", e.id, Q, e.q);
            end
`ifdef MOD_COUNTER_WRAPCNT_EN
            checks++;
            if (wrap_cnt !== e.w) begin
               errors++;
               $display("FAIL wrap id=%0d got %0d want %0d",
                        e.id, wrap_cnt, e.w);
            end
`endif
         end
      end
   end

   initial begin : stim
      int k;
      // reset
      drv(0, 1, 1, 0, 0, 12, 0, 0);
      drv(0, 1, 1, 0, 0, 12, 0, 0);
      // up count modulo 12: 0..11 then 0, tc at 11
      for (int i = 0; i < 12; i++)
         drv(1, 1, 1, 0, 0, 12, (i == 11) ? 4'd0 : 4'(i + 1), i == 11);
      drv(1, 1, 1, 0, 0, 12, 1, 0);
      // down with modulus 10
      drv(1, 1, 0, 0, 0, 10, 0, 0);
      drv(1, 1, 0, 0, 0, 10, 9, 1);
      drv(1, 1, 0, 0, 0, 10, 8, 0);
      drv(1, 1, 0, 0, 0, 10, 7, 0);
      // full range via modulus 0
      drv(1, 1, 1, 1, 13, 0, 13, 0);
      drv(1, 1, 1, 0, 0, 0, 14, 0);
      drv(1, 1, 1, 0, 0, 0, 15, 0);
      drv(1, 1, 1, 0, 0, 0, 0, 1);
      // degenerate modulus 1, both directions
      drv(1, 1, 1, 0, 0, 1, 0, 1);
      drv(1, 1, 1, 0, 0, 1, 0, 1);
      drv(1, 1, 0, 0, 0, 1, 0, 1);
      drv(1, 1, 0, 0, 0, 1, 0, 1);
      // out-of-range load, then up and down re-entry
      drv(1, 0, 1, 1, 14, 12, 14, 0);
      drv(1, 1, 1, 0, 0, 12, 0, 1);
      drv(1, 0, 0, 1, 14, 12, 14, 0);
      drv(1, 1, 0, 0, 0, 12, 11, 0);
      // load beats enable at terminal value, then hold
      drv(1, 1, 1, 1, 3, 12, 3, 0);
      drv(1, 0, 1, 0, 0, 12, 3, 0);
      // mid-run reset
      drv(1, 0, 1, 1, 7, 12, 7, 0);
      drv(0, 1, 1, 0, 0, 12, 0, 0);
      drv(1, 1, 1, 0, 0, 12, 1, 0);
      drv(1, 1, 1, 0, 0, 12, 2, 0);
      drv(1, 1, 1, 0, 0, 12, 3, 0);
      // ten wraps with modulus 2, then load clears wrap count
      drv(1, 0, 1, 1, 0, 2, 0, 0);
      for (int i = 0; i < 20; i++)
         drv(1, 1, 1, 0, 0, 2, (i % 2 == 0) ? 4'd1 : 4'd0, i % 2 == 1);
      drv(1, 0, 1, 1, 0, 2, 0, 0);
      drv(1, 0, 1, 0, 0, 2, 0, 0);
      // drain
      @(negedge clk);
      reset_n = 1'b1;
      enable  = 1'b0;
      load    = 1'b0;
      k = 0;
      while (sb.size() != 0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain left %0d want 0", sb.size());
      end
      @(posedge clk);
      #3;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
